// File: rtl/ifetch_unit.sv
// Multi-cycle instruction fetch stage: owns the PC, fetches one word at a time over req/ack, honours redirects.
// Optional IFETCH_MISALIGN_CHECK_EN: misaligned redirect targets raise a sticky error and halt fetching.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] pc_plus4_reg;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] inst_reg, inst_next;
    logic        discard_reg, discard_next;
    logic        halt_pend_reg, halt_pend_next;
    logic        err_reg, err_next;

    logic [31:0] target;
    logic        target_bad;
    logic        redir_ok;
    logic        redir_bad;

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign target     = redirect_pc;
    assign target_bad = |redirect_pc[1:0];
`else
    // Without the check, the low bits of a redirect target are simply dropped.
    assign target     = redirect_pc & 32'hFFFF_FFFC;
    assign target_bad = 1'b0;
`endif

    assign redir_ok  = redirect_valid & ~target_bad;
    assign redir_bad = redirect_valid & target_bad;

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        addr_next      = addr_reg;
        inst_next      = inst_reg;
        discard_next   = discard_reg;
        halt_pend_next = halt_pend_reg;
        err_next       = err_reg;

        case (state_reg)
            ST_RST: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (halt_pend_reg) begin
                    // Let the outstanding request finish before dropping req.
                    if (imem_ack) begin
                        state_next = ST_HALT;
                    end
                end else if (imem_ack) begin
                    if (redir_bad) begin
                        err_next   = 1'b1;
                        state_next = ST_HALT;
                    end else if (redir_ok) begin
                        pc_next      = target;
                        addr_next    = target;
                        discard_next = 1'b0;
                    end else if (discard_reg) begin
                        discard_next = 1'b0;
                        addr_next    = pc_reg;
                    end else begin
                        inst_next  = imem_rdata;
                        state_next = ST_VALID;
                    end
                end else begin
                    if (redir_bad) begin
                        err_next       = 1'b1;
                        halt_pend_next = 1'b1;
                    end else if (redir_ok) begin
                        pc_next      = target;
                        discard_next = 1'b1;
                    end
                end
            end
            ST_VALID: begin
                if (redir_bad) begin
                    err_next   = 1'b1;
                    inst_next  = NOP_INST;
                    state_next = ST_HALT;
                end else if (redir_ok) begin
                    pc_next    = target;
                    addr_next  = target;
                    inst_next  = NOP_INST;
                    state_next = ST_FETCH;
                end else if (!stall) begin
                    pc_next    = pc_reg + 32'd4;
                    addr_next  = pc_reg + 32'd4;
                    inst_next  = NOP_INST;
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_RST;
            pc_reg        <= RESET_PC;
            pc_plus4_reg  <= RESET_PC + 32'd4;
            addr_reg      <= RESET_PC;
            inst_reg      <= NOP_INST;
            discard_reg   <= 1'b0;
            halt_pend_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            pc_plus4_reg  <= pc_next + 32'd4;
            addr_reg      <= addr_next;
            inst_reg      <= inst_next;
            discard_reg   <= discard_next;
            halt_pend_reg <= halt_pend_next;
            err_reg       <= err_next;
        end
    end

    assign imem_req     = (state_reg == ST_FETCH);
    assign inst_valid   = (state_reg == ST_VALID);
    assign imem_addr    = addr_reg;
    assign inst         = inst_reg;
    assign pc           = pc_reg;
    assign pc_plus4     = pc_plus4_reg;
    assign misalign_err = err_reg;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios then random traffic against a behavioural fetch model.
module tb_ifetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    // Reference model: what the fetch stage should be doing, in words.
    bit          m_started;   // left the post-reset cycle
    bit          m_fetching;  // a memory request is being presented
    bit          m_have;      // an instruction is being presented to decode
    bit          m_halted;
    bit          m_halt_after; // halt once the outstanding request returns
    bit          m_drop;      // next returned word belongs to a stale address
    bit          m_err;
    logic [31:0] m_pc;
    logic [31:0] m_addr;

    ifetch_unit #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall),
        .inst_valid(inst_valid), .inst(inst), .pc(pc), .pc_plus4(pc_plus4),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h2468_ACE1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_fetching = 0; m_have = 0; m_halted = 0;
        m_halt_after = 0; m_drop = 0; m_err = 0;
        m_pc = RST_PC; m_addr = RST_PC;
    endtask

    task automatic check_outputs(input string ctx);
        chk({ctx, ":req"},   {31'd0, imem_req}, {31'd0, m_started & m_fetching & ~m_halted});
        chk({ctx, ":addr"},  imem_addr, m_addr);
        chk({ctx, ":valid"}, {31'd0, inst_valid}, {31'd0, m_have});
        chk({ctx, ":inst"},  inst, m_have ? memfn(m_pc) : NOP);
        chk({ctx, ":pc"},    pc, m_pc);
        chk({ctx, ":pc4"},   pc_plus4, m_pc + 32'd4);
        chk({ctx, ":err"},   {31'd0, misalign_err}, {31'd0, m_err});
    endtask

    // One clock cycle: called at a falling edge, checks, drives inputs, advances the model.
    task automatic step(input string ctx, input bit ack, input bit redir,
                        input logic [31:0] rpc, input bit stl);
        bit          bad;
        logic [31:0] tgt;
        check_outputs(ctx);
        imem_ack       = ack;
        imem_rdata     = ack ? memfn(imem_addr) : 32'hDEAD_BEEF;
        redirect_valid = redir;
        redirect_pc    = rpc;
        stall          = stl;
`ifdef IFETCH_MISALIGN_CHECK_EN
        bad = redir && (rpc[1:0] != 2'b00);
        tgt = rpc;
`else
        bad = 0;
        tgt = {rpc[31:2], 2'b00};
`endif
        if (!m_started) begin
            m_started  = 1;
            m_fetching = 1;
        end else if (m_halted) begin
            // nothing but reset gets out of halt
        end else if (m_fetching) begin
            if (ack) begin
                if (m_halt_after || bad) begin
                    if (bad) m_err = 1;
                    m_halted = 1; m_fetching = 0;
                end else if (redir) begin
                    m_pc = tgt; m_addr = tgt; m_drop = 0;
                end else if (m_drop) begin
                    m_drop = 0; m_addr = m_pc;
                end else begin
                    m_fetching = 0; m_have = 1;
                end
            end else if (!m_halt_after) begin
                if (bad) begin
                    m_err = 1; m_halt_after = 1;
                end else if (redir) begin
                    m_pc = tgt; m_drop = 1;
                end
            end
        end else begin
            if (bad) begin
                m_err = 1; m_halted = 1; m_have = 0;
            end else if (redir) begin
                m_pc = tgt; m_addr = tgt; m_have = 0; m_fetching = 1;
            end else if (!stl) begin
                m_pc = m_pc + 32'd4; m_addr = m_pc; m_have = 0; m_fetching = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must react before any clock edge.
    task automatic async_reset(input string ctx);
        #2 rst = 1'b1;
        #1;
        chk({ctx, ":rst_req"},   {31'd0, imem_req}, 32'd0);
        chk({ctx, ":rst_pc"},    pc, RST_PC);
        chk({ctx, ":rst_valid"}, {31'd0, inst_valid}, 32'd0);
        chk({ctx, ":rst_inst"},  inst, NOP);
        chk({ctx, ":rst_err"},   {31'd0, misalign_err}, 32'd0);
        model_reset();
        imem_ack = 0; redirect_valid = 0; stall = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        imem_ack = 0; imem_rdata = 0; redirect_valid = 0; redirect_pc = 0; stall = 0;
        model_reset();
        #3;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Reset release and zero-wait sequential fetch of 0,4,8
        step("rst_cycle", 1, 0, 0, 0);
        step("fetch0", 1, 0, 0, 0);
        step("valid0", 1, 0, 0, 0);
        step("fetch4", 1, 0, 0, 0);
        step("valid4", 0, 0, 0, 0);
        step("fetch8", 1, 0, 0, 0);
        // Stall three cycles at pc=8
        step("stall1", 1, 0, 0, 1);
        step("stall2", 1, 0, 0, 1);
        step("stall3", 1, 0, 0, 1);
        step("release", 0, 0, 0, 0);
        // Redirect to 0x100 while 0xC is outstanding; ack three cycles later
        step("redir_wait", 0, 1, 32'h100, 0);
        step("wait1", 0, 0, 0, 0);
        step("wait2", 0, 0, 0, 0);
        step("stale_ack", 1, 0, 0, 0);
        step("fetch100", 1, 0, 0, 0);
        // Redirect with stall in VALID, then redirect coinciding with ack
        step("redir_stall", 0, 1, 32'h200, 1);
        step("redir_ack", 1, 1, 32'h300, 0);
        step("fetch300", 1, 0, 0, 0);
        // Wrap-around of the PC at the top of the address space
        step("redir_top", 0, 1, 32'hFFFF_FFFC, 0);
        step("fetch_top", 1, 0, 0, 0);
        step("valid_top", 0, 0, 0, 0);
        step("fetch_wrap", 1, 0, 0, 0);
        // Misaligned redirect target in VALID
        step("misalign", 0, 1, 32'h102, 0);
        step("after_mis1", 1, 1, 32'h400, 0);
        step("after_mis2", 1, 0, 0, 0);
        step("after_mis3", 0, 0, 0, 0);
        // Misaligned redirect while a request is outstanding
        async_reset("rst_a");
        step("rst_cycle_b", 0, 0, 0, 0);
        step("mis_fetch", 0, 1, 32'h0000_0041, 0);
        step("mis_pending", 0, 1, 32'h80, 0);
        step("mis_ack", 1, 0, 0, 0);
        step("mis_after", 1, 0, 0, 0);
        // Reset asserted in the middle of a FETCH
        async_reset("rst_b");
        step("rst_cycle_c", 0, 0, 0, 0);
        step("fetch_hold", 0, 0, 0, 0);
        async_reset("rst_mid_fetch");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] r;
            bit          rd;
            r  = $urandom & 32'h0000_FFFC;
            if ($urandom_range(0, 15) == 0) r[1:0] = 2'($urandom_range(1, 3));
            rd = ($urandom_range(0, 5) == 0);
            step("rand", 1'($urandom_range(0, 1)), rd, r, 1'($urandom_range(0, 2) == 0));
            if (i % 75 == 74) async_reset("rand_rst");
        end
        check_outputs("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
